// File: rtl/skew_delay_line_pkg.sv
// Shared definitions for the skew/deskew delay line: mode encodings and
// the per-lane tap depth rule.
package skew_pkg;

  localparam logic SKEW_MODE_SKEW   = 1'b0;
  localparam logic SKEW_MODE_DESKEW = 1'b1;

  // Skew staggers lane i by i cycles; deskew undoes it with LANES-1-i.
  function automatic int lane_depth(input int lane, input logic mode, input int lanes);
    return (mode == SKEW_MODE_DESKEW) ? (lanes - 1 - lane) : lane;
  endfunction

endpackage

// File: rtl/skew_delay_line_if.sv
// Bundle of the skew delay line's control, input beat and per-lane outputs.
interface skew_delay_line_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 16
);
  // Valid-only stream: a beat is taken at every rising edge with in_valid=1
  // and en=1; there is no ready, so the consumer must take every out_valid.
  logic                    en;
  logic                    flush;
  logic                    mode;
  logic                    in_valid;
  logic [DATA_W*LANES-1:0] in_data;
  logic [DATA_W*LANES-1:0] out_data;
  logic [LANES-1:0]        out_valid;
  logic                    mode_q;
  logic                    drain_busy;

  modport master (
    output en, flush, mode, in_valid, in_data,
    input  out_data, out_valid, mode_q, drain_busy
  );

  modport slave (
    input  en, flush, mode, in_valid, in_data,
    output out_data, out_valid, mode_q, drain_busy
  );
endinterface

// File: rtl/skew_delay_line_lane.sv
// One lane: MAX_D-deep data+valid shift chain with a runtime output tap.
// Build option SKEW_ZERO_FILL_EN forces out_data to 0 whenever out_valid=0.
module skew_lane #(
  parameter int DATA_W  = 8,
  parameter int MAX_D   = 15,
  parameter int DEPTH_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [DEPTH_W-1:0] depth,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic               busy
);

  logic [DATA_W-1:0] data_q [MAX_D];
  logic [DATA_W-1:0] data_d [MAX_D];
  logic [MAX_D-1:0]  valid_q;
  logic [MAX_D-1:0]  valid_d;
  logic [DATA_W-1:0] tap_data;
  logic              tap_valid;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      for (int k = 0; k < MAX_D; k++) data_d[k] = '0;
      valid_d = '0;
    end else if (en) begin
      data_d[0]  = in_data;
      valid_d[0] = in_valid;
      for (int k = 1; k < MAX_D; k++) begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MAX_D; k++) data_q[k] <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Depth 0 bypasses the chain; a stalled beat is not taken, so it is not valid.
  always_comb begin
    tap_data  = in_data;
    tap_valid = in_valid & en;
    for (int k = 0; k < MAX_D; k++) begin
      if (depth == DEPTH_W'(k + 1)) begin
        tap_data  = data_q[k];
        tap_valid = valid_q[k];
      end
    end
  end

  assign out_valid = tap_valid;
`ifdef SKEW_ZERO_FILL_EN
  assign out_data  = tap_valid ? tap_data : '0;
`else
  assign out_data  = tap_data;
`endif

  assign busy = (depth != '0) && (|valid_q);

endmodule

// File: rtl/skew_delay_line.sv
// Per-lane skew/deskew delay line with runtime mode, stall, flush and drain status.
// Build option SKEW_ZERO_FILL_EN zero-fills lanes whose out_valid is low.
module skew_delay_line
  import skew_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 16
) (
  input logic              clk,
  input logic              reset,
  skew_delay_line_if.slave bus
);

  localparam int MAX_D   = LANES - 1;
  localparam int DEPTH_W = $clog2(LANES);

  logic                    mode_q;
  logic                    mode_d;
  logic                    drain_busy;
  logic [LANES-1:0]        lane_busy;
  logic [LANES-1:0]        out_valid;
  logic [DATA_W*LANES-1:0] out_data;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DEPTH_W-1:0] depth;
    assign depth = DEPTH_W'(lane_depth(i, mode_q, LANES));

    skew_lane #(
      .DATA_W  (DATA_W),
      .MAX_D   (MAX_D),
      .DEPTH_W (DEPTH_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .en        (bus.en),
      .flush     (bus.flush),
      .in_valid  (bus.in_valid),
      .in_data   (bus.in_data[i*DATA_W +: DATA_W]),
      .depth     (depth),
      .out_data  (out_data[i*DATA_W +: DATA_W]),
      .out_valid (out_valid[i]),
      .busy      (lane_busy[i])
    );
  end

  assign drain_busy = |lane_busy;

  // Mode only changes on an empty array with no beat entering, so no beat
  // ever sees two different depths on its way through.
  always_comb begin
    mode_d = mode_q;
    if (!drain_busy && !(bus.in_valid && bus.en)) mode_d = bus.mode;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mode_q <= SKEW_MODE_SKEW;
    else       mode_q <= mode_d;
  end

  assign bus.out_data   = out_data;
  assign bus.out_valid  = out_valid;
  assign bus.mode_q     = mode_q;
  assign bus.drain_busy = drain_busy;

endmodule

// File: tb/tb_skew_delay_line.sv
// Bench for skew_delay_line (LANES=4, DATA_W=8): directed steps then random
// traffic, checked against a model of beats indexed by advance count.
module tb_skew_delay_line;

  localparam int DW    = 8;
  localparam int LANES = 4;
  localparam int W     = DW * LANES;
  localparam int MAX_D = LANES - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  // Model: every advancing edge records what entered; lane i with delay d
  // shows the entry recorded d advances ago. Flush/reset forget everything.
  logic         hv [int];
  logic [W-1:0] hd [int];
  int           en_cnt = 0;
  logic         mode_m = 1'b0;

  skew_delay_line_if #(.DATA_W(DW), .LANES(LANES)) bus ();

  skew_delay_line #(.DATA_W(DW), .LANES(LANES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void model_out(output logic [LANES-1:0] ev,
                                    output logic [W-1:0] ed, output logic eb);
    ev = '0;
    ed = '0;
    eb = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      int d;
      d = mode_m ? (LANES - 1 - i) : i;
      if (d == 0) begin
        ev[i] = bus.in_valid & bus.en;
        ed[i*DW +: DW] = bus.in_data[i*DW +: DW];
      end else if (hv.exists(en_cnt - d)) begin
        ev[i] = hv[en_cnt - d];
        ed[i*DW +: DW] = hd[en_cnt - d][i*DW +: DW];
      end
`ifdef SKEW_ZERO_FILL_EN
      if (!ev[i]) ed[i*DW +: DW] = '0;
`endif
    end
    for (int k = 1; k <= MAX_D; k++)
      if (hv.exists(en_cnt - k) && hv[en_cnt - k]) eb = 1'b1;
  endfunction

  task automatic check_all();
    logic [LANES-1:0] ev;
    logic [W-1:0]     ed;
    logic             eb;
    model_out(ev, ed, eb);
    tests++;
    assert (bus.out_valid === ev) else begin
      fails++;
      $error("FAIL out_valid t=%0t got=%b exp=%b", $time, bus.out_valid, ev);
    end
    tests++;
    assert (bus.out_data === ed) else begin
      fails++;
      $error("FAIL out_data t=%0t got=%h exp=%h", $time, bus.out_data, ed);
    end
    tests++;
    assert (bus.drain_busy === eb) else begin
      fails++;
      $error("FAIL drain_busy t=%0t got=%b exp=%b", $time, bus.drain_busy, eb);
    end
    tests++;
    assert (bus.mode_q === mode_m) else begin
      fails++;
      $error("FAIL mode_q t=%0t got=%b exp=%b", $time, bus.mode_q, mode_m);
    end
  endtask

  task automatic edge_update();
    logic [LANES-1:0] ev;
    logic [W-1:0]     ed;
    logic             busy;
    model_out(ev, ed, busy);
    if (!busy && !(bus.in_valid && bus.en)) mode_m = bus.mode;
    if (bus.flush) begin
      hv.delete();
      hd.delete();
    end else if (bus.en) begin
      hv[en_cnt] = bus.in_valid;
      hd[en_cnt] = bus.in_data;
      en_cnt++;
    end
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic step(input logic v, input logic [W-1:0] d, input logic e,
                      input logic f, input logic m);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.en       = e;
    bus.flush    = f;
    bus.mode     = m;
    #2;
    check_all();
    @(posedge clk);
    edge_update();
    @(negedge clk);
  endtask

  task automatic reset_mid(input logic v, input logic [W-1:0] d, input logic e,
                           input logic m);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.en       = e;
    bus.flush    = 1'b0;
    bus.mode     = m;
    #2;
    reset = 1'b1;
    #1;
    hv.delete();
    hd.delete();
    mode_m = 1'b0;
    check_all();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle(input int n, input logic m);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b1, 1'b0, m);
  endtask

  initial begin
    logic [W-1:0] beat;
    logic         rm;
    beat = {8'd44, 8'd33, 8'd22, 8'd11};

    // Reset with a beat presented: only the pass-through lane shows valid.
    reset_mid(1'b1, beat, 1'b1, 1'b0);

    // Skew: single beat drains diagonally.
    step(1'b1, beat, 1'b1, 1'b0, 1'b0);
    idle(5, 1'b0);

    // Switch to deskew while empty, then one beat and a 4-beat burst.
    idle(1, 1'b1);
    step(1'b1, beat, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, $urandom, 1'b1, 1'b0, 1'b1);
    idle(5, 1'b1);

    // Back to skew, then a stall of two cycles mid-drain.
    idle(1, 1'b0);
    step(1'b1, beat, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h5a5a5a5a, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h5a5a5a5a, 1'b0, 1'b0, 1'b0);
    idle(5, 1'b0);

    // Mode request raised while busy must wait for the drain.
    step(1'b1, beat, 1'b1, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b1, 1'b0, 1'b1);
    idle(6, 1'b1);
    step(1'b1, beat, 1'b1, 1'b0, 1'b1);
    idle(5, 1'b1);
    idle(1, 1'b0);

    // Flush collides with an accepted beat mid-drain.
    step(1'b1, beat, 1'b1, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
    idle(4, 1'b0);

    // Asynchronous reset in the middle of a deskew drain.
    idle(1, 1'b1);
    step(1'b1, beat, 1'b1, 1'b0, 1'b1);
    step(1'b1, $urandom, 1'b1, 1'b0, 1'b1);
    reset_mid(1'b0, '0, 1'b1, 1'b1);
    idle(4, 1'b1);

    // Random traffic including stalls, flushes and mode requests.
    rm = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) rm = ~rm;
      if (n == 200) reset_mid(1'($urandom_range(0, 1)), $urandom, 1'b1, rm);
      else step($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 4) != 0,
                $urandom_range(0, 24) == 0, rm);
    end
    idle(5, rm);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
